// File: rtl/key_schedule_reverse_if.sv
// Handshake/bus bundle for key_schedule_reverse.
//   signal_start   : start request, sampled on the clock edge
//   key            : 128-bit master key {l0, k0}, captured on the accepted start edge
//   key_ready      : consumer accepts round_key when key_ready and key_valid are both high
//   round_key      : decryption round key k_i
//   round_idx      : index i of round_key
//   key_valid      : round_key/round_idx are valid
//   finished       : high once all 32 keys have been accepted
//   state_response : FSM state (IDLE=0, FORWARD=1, REVERSE=2, DONE=3)
// master = key requester/consumer, slave = key schedule block.
interface key_schedule_reverse_if;
    logic         signal_start;
    logic [127:0] key;
    logic         key_ready;
    logic [63:0]  round_key;
    logic [4:0]   round_idx;
    logic         key_valid;
    logic         finished;
    logic [3:0]   state_response;

    modport master (
        output signal_start,
        output key,
        output key_ready,
        input  round_key,
        input  round_idx,
        input  key_valid,
        input  finished,
        input  state_response
    );

    modport slave (
        input  signal_start,
        input  key,
        input  key_ready,
        output round_key,
        output round_idx,
        output key_valid,
        output finished,
        output state_response
    );
endinterface

// File: rtl/key_schedule_reverse.sv
// SPECK128/128 key schedule producing round keys in reverse order (k31 down to k0).
// The forward schedule is run to k31 first, then each round key is recovered by
// inverting one forward step, so only the current (l, k) pair is ever stored.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : key_schedule_reverse_if.slave (start/key in, round key stream out)
module key_schedule_reverse (
    input logic                  clk,
    input logic                  rst,
    key_schedule_reverse_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StForward = 2'd1,
        StReverse = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] l_q, l_d;
    logic [63:0] k_q, k_d;
    logic [4:0]  i_q, i_d;

    // Forward step i -> i+1
    logic [63:0] fwd_l, fwd_k;
    // Reverse step i -> i-1
    logic [63:0] rev_x, rev_y, rev_l, rev_k;
    logic [4:0]  i_m1;

    always_comb begin
        fwd_l = (k_q + {l_q[7:0], l_q[63:8]}) ^ {59'd0, i_q};
        fwd_k = {k_q[60:0], k_q[63:61]} ^ fwd_l;

        i_m1  = i_q - 5'd1;
        rev_x = k_q ^ l_q;
        rev_k = {rev_x[2:0], rev_x[63:3]};
        rev_y = (l_q ^ {59'd0, i_m1}) - rev_k;
        rev_l = {rev_y[55:0], rev_y[63:56]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            l_q     <= 64'd0;
            k_q     <= 64'd0;
            i_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            k_q     <= k_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        k_d     = k_q;
        i_d     = i_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.signal_start) begin
                    l_d     = bus.key[127:64];
                    k_d     = bus.key[63:0];
                    i_d     = 5'd0;
                    state_d = StForward;
                end
            end
            StForward: begin
                l_d = fwd_l;
                k_d = fwd_k;
                i_d = i_q + 5'd1;
                // Step 30 produces k31, the first key to emit
                if (i_q == 5'd30) begin
                    state_d = StReverse;
                end
            end
            StReverse: begin
                if (bus.key_ready) begin
                    if (i_q != 5'd0) begin
                        l_d = rev_l;
                        k_d = rev_k;
                        i_d = i_m1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only
    assign bus.round_key      = k_q;
    assign bus.round_idx      = i_q;
    assign bus.key_valid      = (state_q == StReverse);
    assign bus.finished       = (state_q == StDone);
    assign bus.state_response = {2'b00, state_q};
endmodule

// File: tb/tb_key_schedule_reverse.sv
module tb_key_schedule_reverse;
    logic clk;
    logic rst;
    key_schedule_reverse_if bus ();

    key_schedule_reverse dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model: forward key table plus a coarse phase tracker
    logic [63:0] m_ks [32];
    int          m_mode;  // 0 idle, 1 forward, 2 reverse, 3 done
    int          m_cnt;
    int          m_idx;

    logic [63:0] em_key [$];
    int          em_idx [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_ks(input logic [127:0] kk);
        logic [63:0] l, k;
        l = kk[127:64];
        k = kk[63:0];
        m_ks[0] = k;
        for (int i = 0; i < 31; i++) begin
            l = (k + ((l >> 8) | (l << 56))) ^ 64'(i);
            k = ((k << 3) | (k >> 61)) ^ l;
            m_ks[i + 1] = k;
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_idx  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_round_key"}, bus.round_key, 64'd0);
        chk({tag, "_round_idx"}, 64'(bus.round_idx), 64'd0);
        chk({tag, "_key_valid"}, 64'(bus.key_valid), 64'd0);
        chk({tag, "_finished"}, 64'(bus.finished), 64'd0);
        chk({tag, "_state"}, 64'(bus.state_response), 64'd0);
    endtask

    // One clock: record accepted key, advance model, compare outputs after the edge
    task automatic tick();
        logic        acc;
        logic [63:0] rk;
        int          ri;
        acc = bus.key_valid && bus.key_ready;
        rk  = bus.round_key;
        ri  = int'(bus.round_idx);
        @(posedge clk);
        if (acc) begin
            em_key.push_back(rk);
            em_idx.push_back(ri);
        end
        case (m_mode)
            0, 3: if (bus.signal_start) begin
                build_ks(bus.key);
                m_mode = 1;
                m_cnt  = 31;
            end
            1: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_mode = 2;
                    m_idx  = 31;
                end
            end
            2: if (bus.key_ready) begin
                if (m_idx == 0) m_mode = 3;
                else m_idx--;
            end
            default: m_mode = 0;
        endcase
        #1;
        chk("key_valid", 64'(bus.key_valid), 64'(m_mode == 2));
        chk("finished", 64'(bus.finished), 64'(m_mode == 3));
        chk("state_response", 64'(bus.state_response), 64'(m_mode));
        if (m_mode == 2) begin
            chk("round_idx", 64'(bus.round_idx), 64'(m_idx));
            chk("round_key", bus.round_key, m_ks[m_idx]);
        end
    endtask

    // rmode: 0 ready always 1, 1 random ready, 2 ready held low 10 cycles after valid
    task automatic run_seq(input logic [127:0] kk, input int rmode, input bit noise);
        int n, hold;
        bit first_seen, released;
        em_key.delete();
        em_idx.delete();
        bus.key          = kk;
        bus.signal_start = 1'b1;
        bus.key_ready    = 1'($urandom_range(0, 1));
        tick();
        bus.signal_start = 1'b0;
        n = 0;
        hold = 0;
        first_seen = 0;
        released = 0;
        while (m_mode != 3 && n < 600) begin
            if (noise) begin
                bus.key          = {$urandom, $urandom, $urandom, $urandom};
                bus.signal_start = ($urandom_range(0, 3) == 0);
            end
            case (rmode)
                0: bus.key_ready = 1'b1;
                1: bus.key_ready = 1'($urandom_range(0, 1));
                default: bus.key_ready = first_seen && (hold >= 10);
            endcase
            tick();
            n++;
            if (!first_seen && bus.key_valid) begin
                first_seen = 1;
                chk("latency", 64'(n), 64'd31);
            end else if (rmode == 2 && first_seen) begin
                if (!bus.key_ready) begin
                    hold++;
                    chk("hold_idx", 64'(bus.round_idx), 64'd31);
                end else if (!released) begin
                    released = 1;
                    chk("release_idx", 64'(bus.round_idx), 64'd30);
                end
            end
        end
        bus.signal_start = 1'b0;
        if (n >= 600) chk("sequence_timeout", 64'(n), 64'd0);
        chk("emit_count", 64'(em_key.size()), 64'd32);
        for (int j = 0; j < em_key.size() && j < 32; j++) begin
            chk("emit_idx", 64'(em_idx[j]), 64'(31 - j));
            chk("emit_key", em_key[j], m_ks[31 - j]);
        end
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        bus.signal_start = 1'b0;
        bus.key          = '0;
        bus.key_ready    = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Known vector plus literal pins on the model and the emitted stream
        run_seq(128'h0f0e0d0c0b0a0908_0706050403020100, 0, 0);
        chk("model_k1", m_ks[1], 64'h37253b31171d0309);
        chk("model_k0", m_ks[0], 64'h0706050403020100);
        if (em_key.size() == 32) begin
            chk("lit_idx1", em_key[30], 64'h37253b31171d0309);
            chk("lit_idx0", em_key[31], 64'h0706050403020100);
        end
        chk("done_finished", 64'(bus.finished), 64'd1);

        run_seq(128'habababababababababababababababab, 0, 0);
        run_seq(128'h0f0e0d0c0b0a0908_0706050403020100, 1, 0);
        run_seq({$urandom, $urandom, $urandom, $urandom}, 1, 1);
        run_seq(128'h0f0e0d0c0b0a0908_0706050403020100, 2, 0);

        // Asynchronous reset in the middle of the reverse phase
        bus.key          = 128'h0f0e0d0c0b0a0908_0706050403020100;
        bus.signal_start = 1'b1;
        tick();
        bus.signal_start = 1'b0;
        bus.key_ready    = 1'b1;
        n = 0;
        while (!(bus.key_valid && bus.round_idx == 5'd17) && n < 200) begin
            tick();
            n++;
        end
        chk("reach_idx17", 64'(bus.round_idx), 64'd17);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst = 1'b0;
        run_seq(128'h0f0e0d0c0b0a0908_0706050403020100, 0, 0);

        for (int r = 0; r < 3; r++) begin
            run_seq({$urandom, $urandom, $urandom, $urandom}, 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_schedule_reverse.md
KEY_SCHEDULE_REVERSE -- requirements
Module: key_schedule_reverse

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 signal_start  in  1  start request, sampled on the clk edge.
REQ-005 key  in  128  SPECK128/128 master key: {l0 = key[127:64], k0 = key[63:0]}, sampled on the accepted start edge only.
REQ-006 key_ready  in  1  consumer accepts the presented round key when key_ready=1 and key_valid=1 on the same edge.
REQ-007 round_key  out  64  decryption round key k_i, presented in descending i (31 down to 0).
REQ-008 round_idx  out  5  index i of round_key.
REQ-009 key_valid  out  1  round_key/round_idx are valid.
REQ-010 finished  out  1  high while in DONE.
REQ-011 state_response  out  4  FSM state encoding: IDLE=0, FORWARD=1, REVERSE=2, DONE=3.

Function
REQ-012 Arithmetic SHALL be on 64-bit words with alpha=8, beta=3, 32 rounds, and addition/subtraction modulo 2^64.
REQ-013 Forward step (i to i+1): l' = (k + ROR(l,8)) ^ i; k' = ROL(k,3) ^ l'.
REQ-014 Reverse step (i to i-1): k' = ROR(k ^ l,3); l' = ROL((l ^ (i-1)) - k', 8); no key storage beyond the current (l,k) pair SHALL be used.
REQ-015 IDLE: key_valid=0 and finished=0; on an edge with signal_start=1, the block SHALL load l=key[127:64], k=key[63:0] and i=0, then go to FORWARD.
REQ-016 FORWARD: on each edge the block SHALL apply one forward step and increment i; on the edge where step i=30 executes, it SHALL go to REVERSE with i=31. FORWARD therefore lasts exactly 31 cycles.
REQ-017 Latency: with the start accepted at edge E0, key_valid SHALL first be 1 after edge E31, with round_idx=31 and round_key=k31.
REQ-018 REVERSE: key_valid=1, round_key=k, round_idx=i. On each accepting edge with i>=1, the block SHALL apply a reverse step and decrement i. On the accepting edge with i=0, it SHALL go to DONE.
REQ-019 Backpressure: with key_ready=0, round_key, round_idx and internal state SHALL hold unchanged for any number of cycles.
REQ-020 Throughput: with key_ready held at 1, exactly 32 keys SHALL be emitted on 32 consecutive cycles.
REQ-021 DONE: key_valid=0 and finished=1, held until the next start; signal_start=1 in DONE SHALL behave as in IDLE (reload the key, go to FORWARD, finished=0 on the next cycle).
REQ-022 signal_start SHALL be ignored in FORWARD and REVERSE, and key changes outside the start edge SHALL have no effect.
REQ-023 key_ready SHALL be ignored when key_valid=0.
REQ-024 All outputs SHALL be registered or decoded only from registered state; no combinational path SHALL run from inputs to outputs.

Reset
REQ-025 While rst=1, regardless of clk: state=IDLE, state_response=0, key_valid=0, finished=0, round_key=0, round_idx=0, internal l/k/i=0.
REQ-026 Assertion of rst in any state, including mid-FORWARD or mid-REVERSE, SHALL abort the sequence immediately with no further keys emitted.
REQ-027 After rst is released, the first edge SHALL be able to accept signal_start.

Verification
REQ-028 Key 0f0e0d0c0b0a0908_0706050403020100, start pulsed for one cycle, key_ready=1 -> key_valid rises exactly 31 cycles after the start edge; 32 keys are emitted with round_idx 31..0; idx1 = 37253b31171d0309 and idx0 = 0706050403020100; finished=1 afterwards.
REQ-029 Key abababababababababababababababab -> the 32 emitted keys equal the forward key_schedule outputs for the same key, in reverse order (the bench uses a forward-step reference model).
REQ-030 key_ready toggled randomly with 50% density -> the same 32-key sequence as REQ-028 with no duplicates and no skips; outputs stable across every stall cycle.
REQ-031 signal_start pulsed again in FORWARD and in REVERSE -> ignored with the sequence unchanged; start pulsed in DONE with a new key -> new sequence with correct latency.
REQ-032 rst asserted asynchronously (mid-cycle) at round_idx=17 in REVERSE -> all outputs 0 and state_response=0 immediately; a later start produces a full, correct 32-key sequence.
REQ-033 start with key_ready=0 held for 10 cycles after key_valid rises -> round_idx=31 is held for all 10 cycles; on release the next edge advances to idx 30.
